// File: rtl/ov5640_size_cfg.sv
// ---------------------------------------------------------------------------
// ov5640_size_cfg
//
// Turns the selected camera output size and line/frame totals into the fixed
// ten-write OV5640 register sequence. The writes go out one at a time through
// the single-write handshake of the shared SCCB/I2C master. The sequence runs
// once after reset, following a power-up delay. It runs again whenever a
// re-run is requested.
//
// Ports
//   clk            block clock, shared with the I2C master
//   rst            asynchronous reset, active-high
//   cfg_req        one-cycle request for a full re-run of the sequence
//   cmos_h_pixel   output width in pixels              (13 bits)
//   cmos_v_pixel   output height in lines              (13 bits)
//   total_h_pixel  HTS, total line length              (13 bits)
//   total_v_pixel  VTS, total frame length             (13 bits)
//   i2c_done       one-cycle completion pulse from the I2C master
//   i2c_exec       one-cycle start pulse for one write
//   i2c_data       {reg_addr[15:0], reg_data[7:0]}; held until the next write
//   cfg_busy       high while a sequence (including its delays) is running
//   cfg_done       high once a sequence has finished cleanly
//   cfg_err        sticky acknowledge-timeout flag
// ---------------------------------------------------------------------------
module ov5640_size_cfg #(
  parameter logic [15:0] POWER_DLY   = 16'd20000,
  parameter logic [15:0] RST_DLY     = 16'd20000,
  parameter logic [15:0] ACK_TIMEOUT = 16'd65535
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cfg_req,
  input  logic [12:0] cmos_h_pixel,
  input  logic [12:0] cmos_v_pixel,
  input  logic [12:0] total_h_pixel,
  input  logic [12:0] total_v_pixel,
  input  logic        i2c_done,
  output logic        i2c_exec,
  output logic [23:0] i2c_data,
  output logic        cfg_busy,
  output logic        cfg_done,
  output logic        cfg_err
);

  typedef enum logic [2:0] {
    PWR_WAIT,
    LOAD,
    ISSUE,
    WAIT_ACK,
    RST_WAIT,
    IDLE
  } state_e;

  localparam logic [3:0] LAST_IDX = 4'd9;

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;     // shared by both delays and the ack timeout
  logic [3:0]  idx_q, idx_d;
  logic        pend_q, pend_d;
  logic [12:0] h_q, h_d, v_q, v_d, hts_q, hts_d, vts_q, vts_d;
  logic        exec_q, exec_d;
  logic [23:0] data_q, data_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  // Write list entry for a given index and size snapshot.
  function automatic logic [23:0] wr_entry(
    input logic [3:0]  idx,
    input logic [12:0] h,
    input logic [12:0] v,
    input logic [12:0] hts,
    input logic [12:0] vts
  );
    logic [23:0] e;
    case (idx)
      4'd0:    e = {16'h3008, 8'h82};
      4'd1:    e = {16'h3808, 3'b000, h[12:8]};
      4'd2:    e = {16'h3809, h[7:0]};
      4'd3:    e = {16'h380A, 3'b000, v[12:8]};
      4'd4:    e = {16'h380B, v[7:0]};
      4'd5:    e = {16'h380C, 3'b000, hts[12:8]};
      4'd6:    e = {16'h380D, hts[7:0]};
      4'd7:    e = {16'h380E, 3'b000, vts[12:8]};
      4'd8:    e = {16'h380F, vts[7:0]};
      default: e = {16'h3008, 8'h02};
    endcase
    return e;
  endfunction

  always_comb begin
    // NOTE: every variable gets its hold value first, so no path through the
    // case below can leave one unassigned and infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    h_d     = h_q;
    v_d     = v_q;
    hts_d   = hts_q;
    vts_d   = vts_q;
    done_d  = done_q;
    err_d   = err_q;
    // A request seen while busy is remembered. This includes the cycle in
    // which the sequence finishes.
    pend_d  = pend_q | (cfg_req & (state_q != IDLE));

    case (state_q)
      PWR_WAIT: begin
        if (cnt_q == POWER_DLY - 16'd1) begin
          state_d = LOAD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      LOAD: begin
        h_d     = cmos_h_pixel;
        v_d     = cmos_v_pixel;
        hts_d   = total_h_pixel;
        vts_d   = total_v_pixel;
        idx_d   = '0;
        done_d  = 1'b0;
        err_d   = 1'b0;
        state_d = ISSUE;
      end
      ISSUE: begin
        state_d = WAIT_ACK;
        cnt_d   = '0;
      end
      WAIT_ACK: begin
        if (i2c_done) begin
          cnt_d = '0;
          if (idx_q == 4'd0) begin
            state_d = RST_WAIT;
          end else if (idx_q == LAST_IDX) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            idx_d   = idx_q + 4'd1;
            state_d = ISSUE;
          end
        end else if (cnt_q == ACK_TIMEOUT - 16'd1) begin
          cnt_d   = '0;
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      RST_WAIT: begin
        if (cnt_q == RST_DLY - 16'd1) begin
          cnt_d   = '0;
          idx_d   = 4'd1;
          state_d = ISSUE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      IDLE: begin
        if (cfg_req || pend_q) begin
          state_d = LOAD;
          pend_d  = 1'b0;
        end
      end
      default: begin
        state_d = PWR_WAIT;
        cnt_d   = '0;
      end
    endcase

    // The write is registered on entry to ISSUE. A write issued straight
    // from LOAD therefore uses the snapshot taken in that same cycle.
    exec_d = (state_d == ISSUE);
    data_d = exec_d ? wr_entry(idx_d, h_d, v_d, hts_d, vts_d) : data_q;
  end

  // NOTE: state registers use non-blocking assignments only, so every flop
  // samples the values from before the edge, whatever the statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= PWR_WAIT;
      cnt_q   <= '0;
      idx_q   <= '0;
      pend_q  <= 1'b0;
      // NOTE: the size snapshot is reset as well. A sequence reads it only
      // after LOAD, so this is not strictly needed, but it keeps the
      // post-reset state fully defined.
      h_q     <= '0;
      v_q     <= '0;
      hts_q   <= '0;
      vts_q   <= '0;
      exec_q  <= 1'b0;
      data_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      pend_q  <= pend_d;
      h_q     <= h_d;
      v_q     <= v_d;
      hts_q   <= hts_d;
      vts_q   <= vts_d;
      exec_q  <= exec_d;
      data_q  <= data_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign i2c_exec = exec_q;
  assign i2c_data = data_q;
  assign cfg_done = done_q;
  assign cfg_err  = err_q;
  // The state register sits in PWR_WAIT during reset. Gating with rst keeps
  // busy low for as long as reset is applied.
  assign cfg_busy = ~rst & (state_q != IDLE);

endmodule

// File: tb/tb_ov5640_size_cfg.sv
// ---------------------------------------------------------------------------
// Bench for ov5640_size_cfg. It uses short delays: POWER_DLY=10, RST_DLY=6
// and ACK_TIMEOUT=8. An I2C responder returns i2c_done five cycles after
// each exec, unless that write is being withheld. A sequence-level model
// holds the expected write list and predicts handshake timing, hold
// behaviour and completion or timeout status. Directed tests pin the model
// with hand-computed literals.
// ---------------------------------------------------------------------------
module tb_ov5640_size_cfg;

  localparam int RST_DLY     = 6;
  localparam int ACK_TIMEOUT = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_req = 1'b0;
  logic [12:0] h_pix, v_pix, hts_pix, vts_pix;
  logic        i2c_done = 1'b0;
  logic        i2c_exec;
  logic [23:0] i2c_data;
  logic        cfg_busy, cfg_done, cfg_err;

  ov5640_size_cfg #(
    .POWER_DLY  (16'd10),
    .RST_DLY    (16'd6),
    .ACK_TIMEOUT(16'd8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cfg_req      (cfg_req),
    .cmos_h_pixel (h_pix),
    .cmos_v_pixel (v_pix),
    .total_h_pixel(hts_pix),
    .total_v_pixel(vts_pix),
    .i2c_done     (i2c_done),
    .i2c_exec     (i2c_exec),
    .i2c_data     (i2c_data),
    .cfg_busy     (cfg_busy),
    .cfg_done     (cfg_done),
    .cfg_err      (cfg_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int ntot = 0;
  int nbad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntot++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag_fail(input string name);
    ntot++;
    nbad++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // ---------------- model state ----------------
  logic [23:0] exp_q[$];
  logic [23:0] log_q[$];
  int          wr_cnt = 0;
  bit          outstanding = 0;
  bit          out_withheld = 0;
  bit          done_seen = 0;
  bit          fin_pending = 0;
  int          done_cyc, done_pos, exec_cyc, cur_pos;
  logic [23:0] held;
  bit          withhold_en = 0;
  logic [23:0] withhold_data = '0;

  // Expected register writes for one sequence, from plain arithmetic.
  task automatic push_list(input int h, input int v, input int hts, input int vts);
    exp_q.push_back({16'h3008, 8'h82});
    exp_q.push_back({16'h3808, 8'(h / 256)});
    exp_q.push_back({16'h3809, 8'(h % 256)});
    exp_q.push_back({16'h380A, 8'(v / 256)});
    exp_q.push_back({16'h380B, 8'(v % 256)});
    exp_q.push_back({16'h380C, 8'(hts / 256)});
    exp_q.push_back({16'h380D, 8'(hts % 256)});
    exp_q.push_back({16'h380E, 8'(vts / 256)});
    exp_q.push_back({16'h380F, 8'(vts % 256)});
    exp_q.push_back({16'h3008, 8'h02});
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (rst) begin
      outstanding = 0;
      done_seen   = 0;
      fin_pending = 0;
    end else begin
      if (fin_pending) begin
        check("end_busy", 32'(cfg_busy), 0);
        check("end_done", 32'(cfg_done), 1);
        check("end_err", 32'(cfg_err), 0);
        fin_pending = 0;
      end
      if (outstanding) begin
        check("exec_single", 32'(i2c_exec), 0);
        if (out_withheld) begin
          if (cyc - exec_cyc <= ACK_TIMEOUT) begin
            check("to_busy", 32'(cfg_busy), 1);
            check("to_err_low", 32'(cfg_err), 0);
          end else begin
            check("to_err", 32'(cfg_err), 1);
            check("to_done", 32'(cfg_done), 0);
            check("to_idle", 32'(cfg_busy), 0);
            outstanding = 0;
            // The rest of the aborted sequence never goes out.
            while (wr_cnt % 10 != 0 && exp_q.size() > 0) begin
              void'(exp_q.pop_front());
              wr_cnt++;
            end
          end
        end else begin
          check("hold_data", 32'(i2c_data), 32'(held));
          check("wait_busy", 32'(cfg_busy), 1);
          check("wait_done_low", 32'(cfg_done), 0);
          if (i2c_done) begin
            outstanding = 0;
            if (cur_pos == 9) begin
              fin_pending = 1;
            end else begin
              done_seen = 1;
              done_cyc  = cyc;
              done_pos  = cur_pos;
            end
          end
        end
      end else if (i2c_exec) begin
        if (exp_q.size() == 0) begin
          flag_fail($sformatf("unexpected exec data=0x%0h", i2c_data));
        end else begin
          logic [23:0] e;
          e       = exp_q.pop_front();
          cur_pos = wr_cnt % 10;
          wr_cnt++;
          check("wr_data", 32'(i2c_data), 32'(e));
          check("exec_busy", 32'(cfg_busy), 1);
          if (done_seen)
            check("gap", 32'(cyc - done_cyc), (done_pos == 0) ? 32'(RST_DLY + 1) : 32'd1);
          done_seen    = 0;
          outstanding  = 1;
          held         = i2c_data;
          exec_cyc     = cyc;
          out_withheld = withhold_en && (e == withhold_data);
        end
        log_q.push_back(i2c_data);
      end
    end
  end

  // ---------------- I2C responder ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (i2c_exec && !rst && !(withhold_en && i2c_data == withhold_data)) begin
        bit abort;
        abort = 0;
        repeat (5) begin
          @(posedge clk);
          if (rst) abort = 1;
        end
        if (!abort && !rst) begin
          #1 i2c_done = 1'b1;
          @(posedge clk);
          #1 i2c_done = 1'b0;
        end
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic pulse_req();
    @(posedge clk);
    #1 cfg_req = 1'b1;
    @(posedge clk);
    #1 cfg_req = 1'b0;
  endtask

  task automatic set_size(input int h, input int v, input int hts, input int vts);
    h_pix   = 13'(h);
    v_pix   = 13'(v);
    hts_pix = 13'(hts);
    vts_pix = 13'(vts);
  endtask

  task automatic wait_idle(input int budget, input string name);
    bit ok;
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      #2;
      if (exp_q.size() == 0 && !outstanding && !cfg_busy) begin
        ok = 1;
        break;
      end
    end
    if (!ok) flag_fail({name, " timed out waiting for idle"});
  endtask

  task automatic wait_exec_data(input logic [23:0] d, input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      #2;
      if (i2c_exec && i2c_data == d) begin
        ok = 1;
        break;
      end
    end
    if (!ok) flag_fail($sformatf("exec of 0x%0h never seen", d));
  endtask

  localparam logic [23:0] T1_EXP [10] = '{24'h300882, 24'h380803, 24'h380920, 24'h380A01,
    24'h380BE0, 24'h380C07, 24'h380D08, 24'h380E03, 24'h380FE8, 24'h300802};
  localparam logic [23:0] T2_EXP [8] = '{24'h380805, 24'h380900, 24'h380A03, 24'h380B20,
    24'h380C0A, 24'h380D0A, 24'h380E03, 24'h380FD4};

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    int base;
    bit ok;

    // ---- T1: power-up sequence ----
    set_size(800, 480, 1800, 1000);
    repeat (3) @(posedge clk);
    #2;
    check("rst_exec", 32'(i2c_exec), 0);
    check("rst_data", 32'(i2c_data), 0);
    check("rst_busy", 32'(cfg_busy), 0);
    check("rst_done", 32'(cfg_done), 0);
    check("rst_err", 32'(cfg_err), 0);
    push_list(800, 480, 1800, 1000);
    @(posedge clk);
    #1 rst = 1'b0;
    c0 = cyc;
    #1 check("pwr_busy", 32'(cfg_busy), 1);
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #2;
      if (i2c_exec) begin
        ok = 1;
        break;
      end
    end
    if (!ok) flag_fail("first exec never seen");
    else check("first_exec_lat", 32'(cyc - c0), 11);
    wait_idle(500, "t1");
    check("t1_done", 32'(cfg_done), 1);
    check("t1_busy", 32'(cfg_busy), 0);
    check("t1_count", 32'(log_q.size()), 10);
    if (log_q.size() >= 10)
      for (int i = 0; i < 10; i++) check($sformatf("t1_lit%0d", i), 32'(log_q[i]), 32'(T1_EXP[i]));

    // ---- T2: re-run from IDLE with new sizes ----
    set_size(1280, 800, 2570, 980);
    push_list(1280, 800, 2570, 980);
    base = log_q.size();
    pulse_req();
    repeat (2) @(posedge clk);
    #2;
    check("t2_done_clr", 32'(cfg_done), 0);
    check("t2_busy", 32'(cfg_busy), 1);
    wait_idle(500, "t2");
    check("t2_done", 32'(cfg_done), 1);
    check("t2_count", 32'(log_q.size() - base), 10);
    if (log_q.size() >= base + 10)
      for (int i = 0; i < 8; i++) check($sformatf("t2_lit%0d", i), 32'(log_q[base + 1 + i]), 32'(T2_EXP[i]));

    // ---- T3: mid-run input change and coalesced requests ----
    set_size(800, 480, 1800, 1000);
    push_list(800, 480, 1800, 1000);
    base = log_q.size();
    pulse_req();
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #2;
      if (log_q.size() >= base + 4) begin
        ok = 1;
        break;
      end
    end
    if (!ok) flag_fail("t3 write 3 never issued");
    set_size(1024, 600, 1800, 1000);
    push_list(1024, 600, 1800, 1000);
    pulse_req();
    repeat (8) @(posedge clk);
    pulse_req();
    wait_idle(1000, "t3");
    repeat (40) @(posedge clk);
    #2;
    check("t3_no_extra", 32'(log_q.size() - base), 20);
    check("t3_idle", 32'(cfg_busy), 0);
    if (log_q.size() >= base + 20) begin
      check("t3_old_h", 32'(log_q[base + 1]), 32'h380803);
      check("t3_old_hl", 32'(log_q[base + 2]), 32'h380920);
      check("t3_old_v", 32'(log_q[base + 3]), 32'h380A01);
      check("t3_new_h", 32'(log_q[base + 11]), 32'h380804);
      check("t3_new_hl", 32'(log_q[base + 12]), 32'h380900);
      check("t3_new_v", 32'(log_q[base + 13]), 32'h380A02);
      check("t3_new_vl", 32'(log_q[base + 14]), 32'h380B58);
    end

    // ---- T4: acknowledge timeout on write 4 ----
    withhold_data = 24'h380B58;
    withhold_en   = 1;
    push_list(1024, 600, 1800, 1000);
    base = log_q.size();
    pulse_req();
    wait_exec_data(24'h380B58, 200, ok);
    if (ok) begin
      repeat (8) @(posedge clk);
      #2;
      check("t4_err_pre", 32'(cfg_err), 0);
      check("t4_busy_pre", 32'(cfg_busy), 1);
      @(posedge clk);
      #2;
      check("t4_err", 32'(cfg_err), 1);
      check("t4_done", 32'(cfg_done), 0);
      check("t4_busy", 32'(cfg_busy), 0);
    end
    repeat (30) @(posedge clk);
    #2;
    check("t4_no_exec", 32'(log_q.size() - base), 5);
    check("t4_err_sticky", 32'(cfg_err), 1);
    withhold_en = 0;
    push_list(1024, 600, 1800, 1000);
    pulse_req();
    repeat (2) @(posedge clk);
    #2;
    check("t4_err_clr", 32'(cfg_err), 0);
    wait_idle(500, "t4");
    check("t4_rerun_done", 32'(cfg_done), 1);
    check("t4_rerun_err", 32'(cfg_err), 0);

    // ---- T5: asynchronous reset during write 5 ----
    push_list(1024, 600, 1800, 1000);
    pulse_req();
    wait_exec_data(24'h380C07, 200, ok);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("arst_exec", 32'(i2c_exec), 0);
    check("arst_data", 32'(i2c_data), 0);
    check("arst_busy", 32'(cfg_busy), 0);
    check("arst_done", 32'(cfg_done), 0);
    check("arst_err", 32'(cfg_err), 0);
    exp_q.delete();
    wr_cnt = 0;
    repeat (3) @(posedge clk);
    push_list(1024, 600, 1800, 1000);
    base = log_q.size();
    #1 rst = 1'b0;
    wait_idle(500, "t5");
    if (log_q.size() > base) check("t5_first", 32'(log_q[base]), 32'h300882);
    else flag_fail("t5 no write after reset");
    check("t5_done", 32'(cfg_done), 1);

    $display("test done: total=%0d bad=%0d", ntot, nbad);
    $finish;
  end

endmodule
